// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART handshake encodings and FIFO sizing defaults for the TX/RX byte FIFOs.
package uart_tx_fifo_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 4;

  // One-hot handshake states, kept shared so an RX-side FIFO can reuse them.
  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_REQ  = 3'b010,
    S_WAIT = 3'b100
  } hs_state_t;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// 2^ADDR_W x 8 dual-port storage: synchronous write, asynchronous read by address.
module fifo_mem
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [0:(1 << ADDR_W)-1];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; drains one byte per tx_ready/tx_done handshake.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [7:0]      wr_data,
  input  logic            wr_en,
  input  logic            flush,
  output logic            full,
  output logic            empty,
  output logic [ADDR_W:0] count,
  output logic            overflow,
  output logic [7:0]      uart_tx_data,
  output logic            uart_tx_ready,
  input  logic            uart_tx_done
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [7:0]        rd_data;
  logic              push;
  logic              pop;
  hs_state_t         state;

  assign full  = (count == DEPTH);
  assign empty = (count == '0);

  // Flush wins over a same-cycle push and suppresses any dequeue of stale contents.
  assign push = wr_en && !full && !flush;
  assign pop  = (state == S_IDLE) && !empty && uart_tx_done && !flush;

  fifo_mem #(
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clock   (clock),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      if (wr_en && full) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Flush is not seen here beyond gating pop: REQ/WAIT always finish the UART handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      uart_tx_data  <= '0;
      uart_tx_ready <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            uart_tx_data  <= rd_data;
            uart_tx_ready <= 1'b1;
            state         <= S_REQ;
          end
        end
        S_REQ: begin
          if (!uart_tx_done) begin
            uart_tx_ready <= 1'b0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (uart_tx_done) state <= S_IDLE;
        end
        default: begin
          uart_tx_ready <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural UART and a byte scoreboard.
module tb_uart_tx_fifo;

  localparam int unsigned ADDR_W    = 4;
  localparam int          BYTE_TIME = 10;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [7:0]      wr_data = '0;
  logic            wr_en = 1'b0;
  logic            flush = 1'b0;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] count;
  logic            overflow;
  logic [7:0]      uart_tx_data;
  logic            uart_tx_ready;
  logic            uart_tx_done;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         rx_cnt = 0;
  int         busy_cnt = 0;
  logic       uart_hold = 1'b0;
  int         peak = 0;

  uart_tx_fifo #(
    .ADDR_W(ADDR_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .flush         (flush),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .overflow      (overflow),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_ready (uart_tx_ready),
    .uart_tx_done  (uart_tx_done)
  );

  always #5 clock = ~clock;

  assign uart_tx_done = (busy_cnt == 0) && !uart_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // UART model: acts just after the falling edge, busy for BYTE_TIME cycles per byte.
  always @(negedge clock) begin
    #1;
    if (!reset) begin
      busy_cnt = 0;
    end else if (busy_cnt != 0) begin
      busy_cnt = busy_cnt - 1;
    end else if (uart_tx_ready && uart_tx_done) begin
      chk("uart_rx_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("uart_rx_byte", uart_tx_data, exp_q.pop_front());
      rx_cnt++;
      busy_cnt = BYTE_TIME;
    end
  end

  always @(negedge clock) if (int'(count) > peak) peak = int'(count);

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_cnt < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk("wait_rx_timeout", rx_cnt >= n, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!(uart_tx_done && !uart_tx_ready && empty) && k < 60) begin
      @(negedge clock);
      k++;
    end
    chk("wait_idle_timeout", uart_tx_done && !uart_tx_ready && empty, 1);
    repeat (2) @(negedge clock);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!uart_tx_ready && k < 10) begin
      @(negedge clock);
      k++;
    end
    chk("wait_ready_timeout", uart_tx_ready, 1);
  endtask

  initial begin
    int rx_before;
    bit ready_seen;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_ready", uart_tx_ready, 0);
    chk("rst_data", uart_tx_data, 8'h00);
    reset = 1'b1;

    // Single byte write-through latency
    @(negedge clock);
    wr_en = 1'b1; wr_data = 8'h48; exp_q.push_back(8'h48);
    @(negedge clock);
    wr_en = 1'b0;
    chk("t1_c1_count", count, 1);
    chk("t1_c1_ready", uart_tx_ready, 0);
    @(negedge clock);
    chk("t1_c2_ready", uart_tx_ready, 1);
    chk("t1_c2_data", uart_tx_data, 8'h48);
    chk("t1_c2_empty", empty, 1);
    @(negedge clock);
    chk("t1_c3_ready_drop", uart_tx_ready, 0);
    wait_rx(1, 40);
    wait_idle();

    // Burst ordering
    peak = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      wr_en = 1'b1; wr_data = 8'h41 + 8'(i); exp_q.push_back(8'h41 + 8'(i));
    end
    @(negedge clock);
    wr_en = 1'b0;
    wait_rx(rx_cnt + exp_q.size(), 200);
    chk("t2_peak", (peak == 4 || peak == 5), 1);
    chk("t2_sb_empty", exp_q.size(), 0);
    chk("t2_rx_total", rx_cnt, 6);
    wait_idle();

    // Full / overflow with UART held busy
    uart_hold = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clock);
      if (i == 16) begin
        chk("t3_full_at16", full, 1);
        chk("t3_ovf_before", overflow, 0);
      end
      wr_en = 1'b1; wr_data = 8'(i);
      if (i < 16) exp_q.push_back(8'(i));
    end
    @(negedge clock);
    wr_en = 1'b0;
    chk("t3_count16", count, 16);
    chk("t3_full", full, 1);
    chk("t3_overflow", overflow, 1);
    uart_hold = 1'b0;
    wait_rx(rx_cnt + 16, 400);
    chk("t3_sb_empty", exp_q.size(), 0);
    wait_idle();

    // Simultaneous push and pop at count 3
    uart_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      wr_en = 1'b1; wr_data = 8'h51 + 8'(i); exp_q.push_back(8'h51 + 8'(i));
    end
    @(negedge clock);
    wr_en = 1'b0;
    chk("t4_count3", count, 3);
    uart_hold = 1'b0;
    wr_en = 1'b1; wr_data = 8'h54; exp_q.push_back(8'h54);
    @(negedge clock);
    wr_en = 1'b0;
    chk("t4_count_hold", count, 3);
    chk("t4_ready", uart_tx_ready, 1);
    chk("t4_oldest", uart_tx_data, 8'h51);
    wait_rx(rx_cnt + 4, 200);
    chk("t4_sb_empty", exp_q.size(), 0);
    chk("t4_ovf_sticky", overflow, 1);
    wait_idle();

    // Flush while a byte is in S_REQ
    uart_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      wr_en = 1'b1; wr_data = 8'h61 + 8'(i); exp_q.push_back(8'h61 + 8'(i));
    end
    @(negedge clock);
    wr_en = 1'b0;
    chk("t5_count5", count, 5);
    uart_hold = 1'b0;
    wait_ready();
    rx_before = rx_cnt;
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    @(negedge clock);
    flush = 1'b0; wr_en = 1'b0;
    exp_q.delete();
    chk("t5_count0", count, 0);
    chk("t5_overflow0", overflow, 0);
    chk("t5_empty", empty, 1);
    ready_seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (uart_tx_ready) ready_seen = 1'b1;
    end
    chk("t5_no_more_ready", ready_seen, 0);
    chk("t5_inflight_done", rx_cnt, rx_before + 1);
    wait_idle();

    // Asynchronous reset while in S_WAIT with count 7
    uart_hold = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      wr_en = 1'b1; wr_data = 8'h70 + 8'(i); exp_q.push_back(8'h70 + 8'(i));
    end
    @(negedge clock);
    wr_en = 1'b0;
    uart_hold = 1'b0;
    wait_ready();
    @(negedge clock);
    chk("t6_pre_ready", uart_tx_ready, 0);
    chk("t6_pre_count7", count, 7);
    chk("t6_pre_data", uart_tx_data, 8'h70);
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk("t6_count", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_full", full, 0);
    chk("t6_overflow", overflow, 0);
    chk("t6_ready", uart_tx_ready, 0);
    chk("t6_data", uart_tx_data, 8'h00);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("t6_stays_idle", uart_tx_ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO that decouples transmit-side producers from the UART transmitter. Producers push bytes with a single-cycle strobe. The FIFO drains them one at a time into the UART `tx_data`/`tx_ready` port, pacing on `tx_done`. It sits directly upstream of `UART` and downstream of the transmit muxing, so strings can be queued without stalling on each byte.

## Interface
- `ADDR_W`, 4: log2 of depth; depth = 2^ADDR_W entries of 8 bits.
- `clock`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `wr_data`  in  8  byte to enqueue.
- `wr_en`  in  1  push strobe, one byte per high cycle.
- `flush`  in  1  synchronous clear of contents and `overflow`.
- `full`  out  1  no free entry.
- `empty`  out  1  no stored entry.
- `count`  out  ADDR_W+1  entries stored, 0..2^ADDR_W.
- `overflow`  out  1  sticky: a push was dropped.
- `uart_tx_data`  out  8  byte presented to UART.
- `uart_tx_ready`  out  1  request to UART to start a byte.
- `uart_tx_done`  in  1  UART status: high = idle/finished, low = busy.

## Operation
- Storage: 2^ADDR_W x 8 array, write pointer, read pointer (ADDR_W bits, natural wrap), and a registered `count`. `full` = (count == 2^ADDR_W). `empty` = (count == 0). Both are combinational from `count`.
- Push: when `wr_en` && !`full`, write `wr_data` at the write pointer and increment it. When `wr_en` && `full`, drop the byte, leave the pointers alone, and set `overflow`.
- Drain FSM with three states:
  - S_IDLE: `uart_tx_ready`=0. If !`empty` && `uart_tx_done`, latch `mem[rd_ptr]` into `uart_tx_data`, increment the read pointer, and go to S_REQ.
  - S_REQ: `uart_tx_ready`=1, `uart_tx_data` held. When `uart_tx_done`=0 (UART accepted the byte), drop `uart_tx_ready` and go to S_WAIT.
  - S_WAIT: `uart_tx_ready`=0. When `uart_tx_done`=1, go to S_IDLE.
- Count update: a pop is the S_IDLE dequeue. Push and pop in the same cycle leave `count` unchanged.
- `full` is evaluated on the registered `count`. A push while full is dropped even if a pop happens in the same cycle.
- `flush`:
  - Clears the pointers, `count` and `overflow`.
  - Forces S_IDLE unless the state is S_REQ or S_WAIT; those finish the in-flight byte, so the UART handshake is never broken.
  - `flush` has priority over a simultaneous `wr_en`, which is dropped without setting `overflow`.
- Reset values: pointers 0, `count` 0, `empty` 1, `full` 0, `overflow` 0, `uart_tx_data` 8'h00, `uart_tx_ready` 0, state S_IDLE.
- Reset mid-transfer: all state clears immediately. The UART is reset by the same signal, so no handshake cleanup is needed.

## Timing
- Write-through latency on an empty FIFO with the UART idle:
  - `wr_en` high in cycle 0.
  - `count`=1 in cycle 1; the dequeue happens at the end of cycle 1.
  - `uart_tx_ready`=1 and `uart_tx_data` valid from cycle 2.
- `uart_tx_ready` stays high until the first cycle `uart_tx_done` is sampled low. It falls on the following clock edge.
- Next dequeue happens no earlier than one cycle after `uart_tx_done` returns high, so there is at least one S_IDLE cycle between bytes.
- Full throughput for `wr_en`: one push per cycle until `full`.
- `count`, `full`, `empty` reflect operations from the previous edge.

## Structure
- Shared package: UART handshake state encodings (S_IDLE/S_REQ/S_WAIT, one-hot like the top-level FSM) and the default depth constant. These encodings are reused by any future RX-side FIFO.
- One sub-module: `fifo_mem`. It is a 2^ADDR_W x 8 dual-port array with a synchronous write and an asynchronous read by address.
- Pointer/count logic and the drain FSM live in `uart_tx_fifo`.

## Test plan
- Reset then single byte: push 8'h48 in cycle 0 -> `uart_tx_ready`=1 with `uart_tx_data`=8'h48 in cycle 2; UART model drops `tx_done` -> `uart_tx_ready`=0 next cycle; `empty`=1.
- Burst ordering, ADDR_W=4: push 8'h41..8'h45 back-to-back with a UART model of 10-cycle byte time -> UART receives 41,42,43,44,45 in order; `count` peaks at 4 or 5; no byte repeated or lost.
- Full/overflow: hold `uart_tx_done` low (UART busy) and push 17 bytes 8'h00..8'h10 -> `full`=1 after 16; 8'h10 dropped; `overflow`=1; release UART -> 8'h00..8'h0F emerge.
- Simultaneous push/pop at count=3 -> `count` stays 3; the popped byte is the oldest.
- Flush mid-byte: 5 bytes queued, flush while in S_REQ -> the in-flight byte completes its handshake; `count`=0, `overflow`=0; no further `uart_tx_ready`.
- Async reset asserted while in S_WAIT with count=7 -> all outputs at reset values within the same cycle, independent of `clock`.
